// File: rtl/lane_note_feeder_if.sv
// -----------------------------------------------------------------------------
// lane_note_feeder_if
// Video-slot register bus between the CPU side and the lane note feeder.
//   cs       chip select for this slot
//   write    write strobe (qualified by cs)
//   read     read strobe (reads have no side effects)
//   addr     slot register address, only addr[1:0] is decoded by the feeder
//   wr_data  write data
//   rd_data  read data, driven combinationally by the feeder
// The master modport is the CPU/bench side, the slave modport is the feeder.
// -----------------------------------------------------------------------------
interface lane_note_feeder_if;
  logic        cs;
  logic        write;
  logic        read;
  logic [13:0] addr;
  logic [31:0] wr_data;
  logic [31:0] rd_data;

  modport master (
    output cs,
    output write,
    output read,
    output addr,
    output wr_data,
    input  rd_data
  );

  modport slave (
    input  cs,
    input  write,
    input  read,
    input  addr,
    input  wr_data,
    output rd_data
  );
endinterface

// File: rtl/lane_note_feeder.sv
// -----------------------------------------------------------------------------
// lane_note_feeder
// Upstream feeder for the lane-scrolling video core. The CPU pre-loads a FIFO
// of lane-pattern words; once per scroll step (every dvsr+1 frames) the next
// word is presented on lane_word with a one-cycle lane_load strobe.
//
// Ports:
//   clk        system clock
//   reset      asynchronous, active-high reset
//   x, y       frame-counter column / row; (0,0) marks start of frame
//   bus        slot register bus (slave side)
//                addr 00 W: push wr_data[15:0]
//                addr 01 W: dvsr <= wr_data[7:0], frame count restarts
//                addr 10 W: ctrl: bit0 enable, bit1 clear FIFO, bit2 clear flags
//                any addr R: {enable, dvsr, count, ovf, unf, full, empty}
//   lane_word  current lane pattern, lane i at bits [2i+1:2i]
//   lane_load  one-cycle strobe, lane_word updated this cycle
// -----------------------------------------------------------------------------
module lane_note_feeder #(
  parameter int ADDR_WIDTH = 6,
  parameter int LANE_COUNT = 8,
  parameter int LANE_WIDTH = 2,
  parameter int DVSR_WIDTH = 8
) (
  input  logic                             clk,
  input  logic                             reset,
  input  logic [10:0]                      x,
  input  logic [10:0]                      y,
  lane_note_feeder_if.slave                bus,
  output logic [LANE_COUNT*LANE_WIDTH-1:0] lane_word,
  output logic                             lane_load
);

  localparam int WORD_WIDTH = LANE_COUNT * LANE_WIDTH;

  localparam logic [ADDR_WIDTH:0]   FULL_COUNT = {1'b1, {ADDR_WIDTH{1'b0}}};
  localparam logic [ADDR_WIDTH:0]   CNT_ONE    = {{ADDR_WIDTH{1'b0}}, 1'b1};
  localparam logic [ADDR_WIDTH-1:0] PTR_ONE    = {{(ADDR_WIDTH-1){1'b0}}, 1'b1};
  localparam logic [DVSR_WIDTH-1:0] FCNT_ONE   = {{(DVSR_WIDTH-1){1'b0}}, 1'b1};

  // Storage and state
  logic [WORD_WIDTH-1:0] mem_r [(1<<ADDR_WIDTH)-1:0];
  logic [ADDR_WIDTH-1:0] wr_ptr_r;
  logic [ADDR_WIDTH-1:0] rd_ptr_r;
  logic [ADDR_WIDTH:0]   count_r;
  logic [DVSR_WIDTH-1:0] dvsr_r;
  logic [DVSR_WIDTH-1:0] fcnt_r;
  logic                  enable_r;
  logic                  underflow_r;
  logic                  overflow_r;
  logic                  sof_d_r;
  logic [WORD_WIDTH-1:0] lane_word_r;
  logic                  lane_load_r;

  // Decoded controls
  logic                  push_req_s;
  logic                  dvsr_wr_s;
  logic                  ctrl_wr_s;
  logic                  fifo_clr_s;
  logic                  flag_clr_s;
  logic                  tick_s;
  logic                  step_s;
  logic                  empty_s;
  logic                  full_s;
  logic                  fetch_s;
  logic                  pop_s;
  logic                  blank_s;
  logic                  push_s;
  logic                  drop_s;
  logic [31:0]           rd_data_s;
  logic                  unused_bus_s;

  // Register decode, frame tick, step and FIFO push/pop arbitration
  always_comb begin
    push_req_s = 1'b0;
    dvsr_wr_s  = 1'b0;
    ctrl_wr_s  = 1'b0;
    if (bus.cs && bus.write) begin
      case (bus.addr[1:0])
        2'b00:   push_req_s = 1'b1;
        2'b01:   dvsr_wr_s  = 1'b1;
        2'b10:   ctrl_wr_s  = 1'b1;
        default: ctrl_wr_s  = 1'b0;
      endcase
    end else begin
      ctrl_wr_s = 1'b0;
    end

    fifo_clr_s = ctrl_wr_s & bus.wr_data[1];
    flag_clr_s = ctrl_wr_s & bus.wr_data[2];

    // One tick per frame: only the first cycle the counter sits at (0,0)
    tick_s  = (x == 11'd0) && (y == 11'd0) && !sof_d_r;
    step_s  = tick_s && (fcnt_r == dvsr_r);

    empty_s = (count_r == {(ADDR_WIDTH+1){1'b0}});
    full_s  = (count_r == FULL_COUNT);

    // A same-cycle clear empties the FIFO first, so the row reads as blank
    fetch_s = step_s & enable_r;
    pop_s   = fetch_s & ~empty_s & ~fifo_clr_s;
    blank_s = fetch_s & (empty_s | fifo_clr_s);

    // At full a same-cycle pop frees the slot, so the push is kept
    push_s  = push_req_s & ~fifo_clr_s & (~full_s | pop_s);
    drop_s  = push_req_s & ~fifo_clr_s & full_s & ~pop_s;
  end

  // Status word returned on every read
  always_comb begin
    rd_data_s                     = 32'd0;
    rd_data_s[0]                  = empty_s;
    rd_data_s[1]                  = full_s;
    rd_data_s[2]                  = underflow_r;
    rd_data_s[3]                  = overflow_r;
    rd_data_s[8 +: ADDR_WIDTH+1]  = count_r;
    rd_data_s[16 +: DVSR_WIDTH]   = dvsr_r;
    rd_data_s[24]                 = enable_r;
  end

  assign bus.rd_data = rd_data_s;
  assign lane_word   = lane_word_r;
  assign lane_load   = lane_load_r;

  // Bus bits the feeder does not decode
  assign unused_bus_s = ^{bus.read, bus.addr[13:2], bus.wr_data[31:WORD_WIDTH]};

  // FIFO data array (no reset needed, validity tracked by count)
  always_ff @(posedge clk) begin
    if (push_s) begin
      mem_r[wr_ptr_r] <= bus.wr_data[WORD_WIDTH-1:0];
    end
  end

  // FIFO pointers and occupancy
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      wr_ptr_r <= {ADDR_WIDTH{1'b0}};
      rd_ptr_r <= {ADDR_WIDTH{1'b0}};
      count_r  <= {(ADDR_WIDTH+1){1'b0}};
    end else if (fifo_clr_s) begin
      wr_ptr_r <= {ADDR_WIDTH{1'b0}};
      rd_ptr_r <= {ADDR_WIDTH{1'b0}};
      count_r  <= {(ADDR_WIDTH+1){1'b0}};
    end else begin
      if (push_s) wr_ptr_r <= wr_ptr_r + PTR_ONE;
      if (pop_s)  rd_ptr_r <= rd_ptr_r + PTR_ONE;
      case ({push_s, pop_s})
        2'b10:   count_r <= count_r + CNT_ONE;
        2'b01:   count_r <= count_r - CNT_ONE;
        default: count_r <= count_r;
      endcase
    end
  end

  // Configuration, frame divider and sticky flags
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      dvsr_r      <= {DVSR_WIDTH{1'b0}};
      fcnt_r      <= {DVSR_WIDTH{1'b0}};
      enable_r    <= 1'b0;
      underflow_r <= 1'b0;
      overflow_r  <= 1'b0;
      sof_d_r     <= 1'b0;
    end else begin
      sof_d_r <= (x == 11'd0) && (y == 11'd0);

      if (dvsr_wr_s) begin
        dvsr_r <= bus.wr_data[DVSR_WIDTH-1:0];
        fcnt_r <= {DVSR_WIDTH{1'b0}};
      end else if (tick_s) begin
        fcnt_r <= step_s ? {DVSR_WIDTH{1'b0}} : fcnt_r + FCNT_ONE;
      end

      if (ctrl_wr_s) enable_r <= bus.wr_data[0];

      // A new event outranks a same-cycle flag clear
      if (blank_s)         underflow_r <= 1'b1;
      else if (flag_clr_s) underflow_r <= 1'b0;

      if (drop_s)          overflow_r  <= 1'b1;
      else if (flag_clr_s) overflow_r  <= 1'b0;
    end
  end

  // Lane output stage: new word or blank row on each enabled step
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      lane_word_r <= {WORD_WIDTH{1'b0}};
      lane_load_r <= 1'b0;
    end else begin
      lane_load_r <= fetch_s;
      if (pop_s)        lane_word_r <= mem_r[rd_ptr_r];
      else if (blank_s) lane_word_r <= {WORD_WIDTH{1'b0}};
      else              lane_word_r <= lane_word_r;
    end
  end

endmodule

// File: tb/tb_lane_note_feeder.sv
// -----------------------------------------------------------------------------
// tb_lane_note_feeder
// Table of directed vectors, hand-written corner sequences and a random phase,
// all compared against constants or a queue-based reference model.
// -----------------------------------------------------------------------------
module tb_lane_note_feeder;

  logic        clk = 1'b0;
  logic        reset;
  logic [10:0] x;
  logic [10:0] y;
  logic [15:0] lane_word;
  logic        lane_load;

  lane_note_feeder_if bus();

  lane_note_feeder #(
    .ADDR_WIDTH(6),
    .LANE_COUNT(8),
    .LANE_WIDTH(2),
    .DVSR_WIDTH(8)
  ) dut (
    .clk      (clk),
    .reset    (reset),
    .x        (x),
    .y        (y),
    .bus      (bus),
    .lane_word(lane_word),
    .lane_load(lane_load)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_fail   = 0;

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%08h, expected 0x%08h", name, got, exp);
    end
  endtask

  // ---------------- reference model ----------------
  logic [15:0] mq[$];
  bit          m_en;
  int          m_dvsr;
  int          m_frames;
  bit          m_unf;
  bit          m_ovf;
  logic [15:0] m_word;

  function automatic void m_reset();
    mq.delete();
    m_en = 0; m_dvsr = 0; m_frames = 0; m_unf = 0; m_ovf = 0; m_word = 16'h0000;
  endfunction

  function automatic void m_push(input logic [15:0] w);
    if (mq.size() == 64) m_ovf = 1;
    else mq.push_back(w);
  endfunction

  // Frames are counted since the last divider write; every (dvsr+1)-th is a step
  function automatic bit m_frame(output logic [15:0] w);
    w = 16'h0000;
    m_frames++;
    if ((m_frames % (m_dvsr + 1)) != 0) return 0;
    if (!m_en) return 0;
    if (mq.size() > 0) w = mq.pop_front();
    else m_unf = 1;
    m_word = w;
    return 1;
  endfunction

  function automatic void m_ctrl_pre(input logic [2:0] v);
    if (v[1]) mq.delete();
    if (v[2]) begin m_unf = 0; m_ovf = 0; end
  endfunction

  function automatic void m_ctrl_post(input logic [2:0] v);
    m_en = v[0];
  endfunction

  function automatic logic [31:0] m_status();
    return {7'd0, m_en, 8'(m_dvsr), 1'b0, 7'(mq.size()), 4'd0,
            m_ovf, m_unf, (mq.size() == 64), (mq.size() == 0)};
  endfunction

  // ---------------- lane_load monitor ----------------
  logic [15:0] got_q[$];
  logic        prev_load = 1'b0;

  always @(negedge clk) begin
    if (lane_load) begin
      got_q.push_back(lane_word);
      check("load_width", {31'd0, prev_load}, 32'd0);
    end
    prev_load <= lane_load;
  end

  // ---------------- stimulus helpers ----------------
  task automatic step_clk();
    @(posedge clk);
    #1;
  endtask

  task automatic bus_wr(input logic [1:0] a, input logic [31:0] d);
    bus.cs = 1'b1; bus.write = 1'b1; bus.addr = {12'd0, a}; bus.wr_data = d;
    step_clk();
    bus.cs = 1'b0; bus.write = 1'b0;
  endtask

  task automatic cpu_push(input logic [15:0] w);
    bus_wr(2'd0, {16'd0, w});
    m_push(w);
  endtask

  task automatic cpu_dvsr(input logic [7:0] d);
    bus_wr(2'd1, {24'd0, d});
    m_dvsr = int'(d); m_frames = 0;
  endtask

  task automatic cpu_ctrl(input logic [2:0] v);
    bus_wr(2'd2, {29'd0, v});
    m_ctrl_pre(v); m_ctrl_post(v);
  endtask

  // One frame: hold cycles at (0,0), then 4 cycles elsewhere (x or y zero
  // alone). kind 1/2 issues a push/ctrl write on the tick cycle itself.
  task automatic run_frame(input int hold, input int kind, input logic [15:0] val,
                           output int nl, output logic [15:0] wg,
                           output bit el, output logic [15:0] ew);
    got_q.delete();
    x = 11'd0; y = 11'd0;
    if (kind == 1) begin
      bus.cs = 1'b1; bus.write = 1'b1; bus.addr = 14'd0; bus.wr_data = {16'd0, val};
    end else if (kind == 2) begin
      bus.cs = 1'b1; bus.write = 1'b1; bus.addr = 14'd2; bus.wr_data = {29'd0, val[2:0]};
    end
    if (kind == 2) m_ctrl_pre(val[2:0]);
    el = m_frame(ew);
    if (kind == 1) m_push(val);
    if (kind == 2) m_ctrl_post(val[2:0]);
    step_clk();
    bus.cs = 1'b0; bus.write = 1'b0;
    for (int i = 1; i < hold; i++) step_clk();
    for (int i = 0; i < 4; i++) begin
      x = i[0] ? 11'd3 : 11'd0;
      y = i[0] ? 11'd0 : 11'd1;
      step_clk();
    end
    nl = got_q.size();
    wg = (nl > 0) ? got_q[0] : 16'h0000;
  endtask

  // Frame compared against the reference model
  task automatic model_frame(input string tag, input int hold, input int kind, input logic [15:0] val);
    int          nl;
    logic [15:0] wg;
    bit          el;
    logic [15:0] ew;
    run_frame(hold, kind, val, nl, wg, el, ew);
    check({tag, "_loads"}, nl, {31'd0, el});
    if (el) check({tag, "_word"}, {16'd0, wg}, {16'd0, ew});
  endtask

  // ---------------- directed vector table ----------------
  localparam int OP_PUSH  = 0;
  localparam int OP_DVSR  = 1;
  localparam int OP_CTRL  = 2;
  localparam int OP_FRAME = 3;   // arg = hold cycles at (0,0)
  localparam int OP_STAT  = 4;   // arg = expected rd_data

  typedef struct {
    int          op;
    logic [31:0] arg;
    int          nload;
    logic [15:0] word;
  } vec_t;

  vec_t tbl[$];

  function automatic void add(input int op, input logic [31:0] arg, input int nl, input logic [15:0] w);
    vec_t v;
    v.op = op; v.arg = arg; v.nload = nl; v.word = w;
    tbl.push_back(v);
  endfunction

  initial begin : watchdog
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin : main
    int          nl;
    logic [15:0] wg;
    bit          el;
    logic [15:0] ew;
    logic [15:0] dw [4];

    dw[0] = 16'hAAAA; dw[1] = 16'h5555; dw[2] = 16'h0F0F; dw[3] = 16'hF0F0;

    // enable=0: no loads for 3 frames, then the 3-word run with dvsr=0
    add(OP_STAT,  32'h0000_0001, 0, 16'h0);
    add(OP_FRAME, 32'd1, 0, 16'h0);
    add(OP_FRAME, 32'd1, 0, 16'h0);
    add(OP_FRAME, 32'd2, 0, 16'h0);
    add(OP_PUSH,  32'h1B1B, 0, 16'h0);
    add(OP_PUSH,  32'hE4E4, 0, 16'h0);
    add(OP_PUSH,  32'h0003, 0, 16'h0);
    add(OP_STAT,  32'h0000_0300, 0, 16'h0);
    add(OP_DVSR,  32'd0, 0, 16'h0);
    add(OP_CTRL,  32'd1, 0, 16'h0);
    add(OP_STAT,  32'h0100_0300, 0, 16'h0);
    add(OP_FRAME, 32'd1, 1, 16'h1B1B);
    add(OP_FRAME, 32'd1, 1, 16'hE4E4);
    add(OP_FRAME, 32'd3, 1, 16'h0003);
    add(OP_STAT,  32'h0100_0001, 0, 16'h0);
    // dvsr=2: step on frames 3, 6, 9, 12; some frames hold (0,0) 4 cycles
    add(OP_DVSR,  32'd2, 0, 16'h0);
    for (int i = 0; i < 4; i++) add(OP_PUSH, {16'd0, dw[i]}, 0, 16'h0);
    for (int f = 1; f <= 12; f++)
      add(OP_FRAME, (f % 2 == 1) ? 32'd4 : 32'd1, (f % 3 == 0) ? 1 : 0,
          (f % 3 == 0) ? dw[f/3 - 1] : 16'h0);
    add(OP_STAT,  32'h0102_0001, 0, 16'h0);
    // empty FIFO with enable: blank row and sticky underflow, then flag clear
    add(OP_DVSR,  32'd0, 0, 16'h0);
    add(OP_FRAME, 32'd1, 1, 16'h0000);
    add(OP_STAT,  32'h0100_0005, 0, 16'h0);
    add(OP_CTRL,  32'd5, 0, 16'h0);
    add(OP_STAT,  32'h0100_0001, 0, 16'h0);

    bus.cs = 1'b0; bus.write = 1'b0; bus.read = 1'b0; bus.addr = 14'd0; bus.wr_data = 32'd0;
    x = 11'd3; y = 11'd0;
    reset = 1'b1;
    m_reset();
    repeat (3) @(posedge clk);
    #1;
    reset = 1'b0;
    check("rst_lane_word", {16'd0, lane_word}, 32'd0);
    check("rst_lane_load", {31'd0, lane_load}, 32'd0);

    foreach (tbl[i]) begin
      case (tbl[i].op)
        OP_PUSH:  cpu_push(tbl[i].arg[15:0]);
        OP_DVSR:  cpu_dvsr(tbl[i].arg[7:0]);
        OP_CTRL:  cpu_ctrl(tbl[i].arg[2:0]);
        OP_FRAME: begin
          run_frame(int'(tbl[i].arg), 0, 16'h0, nl, wg, el, ew);
          check($sformatf("vec%0d_loads", i), nl, tbl[i].nload);
          if (tbl[i].nload == 1)
            check($sformatf("vec%0d_word", i), {16'd0, wg}, {16'd0, tbl[i].word});
        end
        OP_STAT: begin
          bus.read = 1'b1;
          check($sformatf("vec%0d_status", i), bus.rd_data, tbl[i].arg);
          bus.read = 1'b0;
        end
        default: ;
      endcase
    end

    // Overflow: 65 pushes with output disabled; the 65th is dropped
    cpu_ctrl(3'b010);
    for (int i = 0; i < 65; i++) cpu_push(16'h1000 + 16'(i));
    check("ovf_status", bus.rd_data, 32'h0000_400A);
    cpu_ctrl(3'b101);
    run_frame(1, 0, 16'h0, nl, wg, el, ew);
    check("ovf_first_word", {16'd0, wg}, 32'h0000_1000);
    cpu_push(16'h7777);
    check("full_again", bus.rd_data, 32'h0100_4002);
    // Push on the same cycle as a pop at full: accepted, no overflow
    run_frame(2, 1, 16'hBEEF, nl, wg, el, ew);
    check("full_pushpop_word", {16'd0, wg}, 32'h0000_1001);
    check("full_pushpop_status", bus.rd_data, 32'h0100_4002);
    // Drain everything; the dropped word never shows up, the last row is blank
    for (int i = 0; i < 65; i++) model_frame($sformatf("drain%0d", i), 1 + (i % 3), 0, 16'h0);
    check("drain_status", bus.rd_data, m_status());

    // Clear on the same cycle as a step: blank row and underflow
    cpu_ctrl(3'b101);
    for (int i = 0; i < 10; i++) cpu_push(16'h2200 + 16'(i));
    run_frame(1, 2, 16'h0003, nl, wg, el, ew);
    check("clr_step_loads", nl, 32'd1);
    check("clr_step_word", {16'd0, wg}, 32'd0);
    check("clr_step_status", bus.rd_data, 32'h0100_0005);

    // Reset in the middle of a frame with words queued
    cpu_ctrl(3'b101);
    for (int i = 0; i < 5; i++) cpu_push(16'h3300 + 16'(i));
    run_frame(1, 0, 16'h0, nl, wg, el, ew);
    check("pre_rst_word", {16'd0, lane_word}, 32'h0000_3300);
    x = 11'd3; y = 11'd2;
    reset = 1'b1;
    #2;
    check("mid_rst_word", {16'd0, lane_word}, 32'd0);
    check("mid_rst_status", bus.rd_data, 32'h0000_0001);
    step_clk();
    reset = 1'b0;
    m_reset();
    model_frame("post_rst", 1, 0, 16'h0);
    check("post_rst_status", bus.rd_data, m_status());

    // Random operations against the reference model
    for (int it = 0; it < 300; it++) begin
      int          r;
      logic [2:0]  cv;
      r  = int'($urandom_range(0, 9));
      cv = {1'($urandom_range(0, 1)), 1'($urandom_range(0, 7) == 0), 1'($urandom_range(0, 3) != 0)};
      if (r < 4)       cpu_push(16'($urandom));
      else if (r == 4) cpu_dvsr(8'($urandom_range(0, 3)));
      else if (r == 5) cpu_ctrl(cv);
      else if (r == 9) begin
        if ($urandom_range(0, 1) == 1) model_frame($sformatf("rnd%0d", it), int'($urandom_range(1, 4)), 1, 16'($urandom));
        else model_frame($sformatf("rnd%0d", it), int'($urandom_range(1, 4)), 2, {13'd0, cv});
      end
      else model_frame($sformatf("rnd%0d", it), int'($urandom_range(1, 4)), 0, 16'h0);
      check($sformatf("rnd%0d_status", it), bus.rd_data, m_status());
      check($sformatf("rnd%0d_lane_word", it), {16'd0, lane_word}, {16'd0, m_word});
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/lane_note_feeder.md
Name: lane_note_feeder

Overview:
- Upstream feeder for the lane-scrolling video core.
- CPU pre-loads a queue of lane-pattern words (8 lanes × 2-bit colour code = 16 bits) through the video-slot bus.
- Block derives a scroll step from the frame counter and presents one new lane word per step on lane_word, qualified by a one-cycle lane_load strobe.
- Downstream scroller latches lane_word into its per-lane input registers on lane_load, removing per-row CPU writes.

Parameters:
- ADDR_WIDTH, 6, log2 of FIFO depth (64 entries).
- LANE_COUNT, 8, number of lanes.
- LANE_WIDTH, 2, bits per lane code.
- DVSR_WIDTH, 8, width of frames-per-step divider.

Ports:
- clk  in  1  system clock
- reset  in  1  reset
- x  in  11  frame-counter column
- y  in  11  frame-counter row
- cs  in  1  slot chip select
- write  in  1  slot write strobe
- read  in  1  slot read strobe (no side effects)
- addr  in  14  slot register address; only addr[1:0] decoded
- wr_data  in  32  slot write data
- rd_data  out  32  slot read data
- lane_word  out  LANE_COUNT*LANE_WIDTH  current lane pattern, lane i at bits [2i+1:2i]
- lane_load  out  1  one-cycle strobe: lane_word updated this cycle

Behaviour:
- Reset: reset is asynchronous, active-high; clock is clk. Reset clears FIFO (count 0, pointers 0), dvsr=0, enable=0, frame count fcnt=0, underflow=0, overflow=0, lane_word=0, lane_load=0, sof_d=0.
- Register writes (wr_en = cs & write):
  - addr 00: push wr_data[15:0].
  - addr 01: dvsr <= wr_data[7:0]; fcnt <= 0.
  - addr 10: ctrl. bit0 sets enable (level). bit1 clears FIFO (self-clearing). bit2 clears underflow and overflow.
  - addr 11: no effect.
- Reads (combinational, any addr), rd_data:
  - [0] empty, [1] full, [2] underflow, [3] overflow
  - [15:8] count (ADDR_WIDTH+1 bits, zero-extended)
  - [23:16] dvsr
  - [24] enable
  - all other bits 0
- Frame tick: sof = (x==0 && y==0); sof_d registered; tick = sof & ~sof_d. Exactly one tick per frame, however many clk cycles the frame counter holds at (0,0).
- Step divider, on tick:
  - fcnt==dvsr: fcnt <= 0, step=1.
  - otherwise: fcnt <= fcnt+1.
  - dvsr=0 gives a step every frame; dvsr=N gives a step every N+1 frames.
- On step, all results registered, lane_load high exactly the next cycle:
  - enable=1 and FIFO non-empty: pop head; lane_word <= head; lane_load <= 1.
  - enable=1 and FIFO empty: lane_word <= 0 (blank row); lane_load <= 1; underflow <= 1 (sticky).
  - enable=0: no pop; lane_word held; lane_load stays 0; fcnt still advances.
- lane_load is 0 in all other cycles.
- FIFO:
  - Synchronous, 2^ADDR_WIDTH × 16.
  - Push when full: word dropped, overflow <= 1 (sticky).
  - Simultaneous push and pop with FIFO non-empty and not full: both occur, count unchanged.
  - Simultaneous push and pop with FIFO empty: pop is treated as empty (blank row, underflow set) and the push is stored.
  - Simultaneous push and pop with FIFO full: pop occurs, push is accepted, count unchanged, no overflow.
  - Pointers wrap modulo depth.
- Clear (ctrl bit1) has priority over a same-cycle push and pop: FIFO becomes empty and the pop reads as empty (underflow rules apply if a step coincides). lane_word is not cleared.
- Flag clear (ctrl bit2) coinciding with a new underflow or overflow event: the event wins and the flag reads 1.
- Reset asserted mid-frame: all state returns to reset values immediately. After release, the first tick occurs at the next (0,0) edge.

Test Plan:
- Reset, then read status: rd_data = 0x0000_0001 (empty only); lane_word=0; lane_load never asserts over 3 frames with enable=0.
- Push 0x1B1B, 0xE4E4, 0x0003; enable=1; dvsr=0. Over 3 frames, lane_load pulses once per frame, 1 cycle wide, with lane_word 0x1B1B, 0xE4E4, 0x0003 in order. Count then reads 0 with underflow=0.
- dvsr=2 with 4 words queued. Pops occur only on frames 3, 6, 9, 12 after the dvsr write. Holding x=y=0 for 4 clk cycles produces exactly one tick.
- Empty FIFO, enable=1, run 1 frame: lane_word=0x0000, lane_load pulses, rd_data[2]=1. Write ctrl=0x5 → underflow reads 0.
- Push 65 words: count=64, full=1, overflow=1, and the 65th word never appears at lane_word. A push coincident with a pop at full is accepted and count stays 64.
- Queue 10 words, write ctrl bit1 on the same cycle as a step: count=0 and underflow=1. Assert reset mid-frame with 5 words queued: count=0, lane_word=0.
